// File: rtl/nbcac_byte_packer_18.sv
// Byte-to-18-bit LSB-first gearbox with zero-padding flush; a completed word is valid the cycle after its last byte.
// Backpressure: out_data/out_valid hold while out_ready is low; in_ready drops once a full word is waiting or a flush is pending.
module nbcac_byte_packer_18 (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [17:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] word_count
);

    logic [25:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic [15:0] word_count_q, word_count_d;

    logic        in_fire;
    logic        out_fire;
    logic        full_word;
    logic [4:0]  base;
    logic [25:0] in_ext;

    assign full_word = (cnt_q >= 5'd18);
    assign out_valid = full_word | (flush_pend_q & (cnt_q != 5'd0));
    // Bits at and above cnt are kept zero, so a partial word is already padded.
    assign out_data  = acc_q[17:0];
    assign in_ready  = ~flush_pend_q & (~full_word | out_ready);
    assign word_count = word_count_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign in_ext   = {18'd0, in_data};

    always_comb begin
        base         = cnt_q;
        acc_d        = acc_q;
        word_count_d = word_count_q;
        if (out_fire) begin
            base         = full_word ? (cnt_q - 5'd18) : 5'd0;
            acc_d        = acc_q >> 18;
            word_count_d = word_count_q + 16'd1;
        end
        // base never exceeds 17 when a byte lands, so cnt_d tops out at 25.
        if (in_fire) begin
            acc_d = acc_d | (in_ext << base);
        end
        cnt_d = base + (in_fire ? 5'd8 : 5'd0);

        flush_pend_d = flush_pend_q;
        if (cnt_d == 5'd0) begin
            flush_pend_d = 1'b0;
        end else if (flush && (cnt_q != 5'd0)) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= 26'd0;
            cnt_q        <= 5'd0;
            flush_pend_q <= 1'b0;
            word_count_q <= 16'd0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            word_count_q <= word_count_d;
        end
    end

endmodule

// File: tb/tb_nbcac_byte_packer_18.sv
// Bench for nbcac_byte_packer_18: bit-queue reference model checked every cycle plus directed literal cases.
module tb_nbcac_byte_packer_18;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [17:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;

    nbcac_byte_packer_18 dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: stream bits not yet emitted, oldest first.
    bit          mq[$];
    bit          m_fp;
    logic [15:0] m_wc;
    logic [17:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        bit          ev;
        bit          er;
        bit          of;
        bit          inf;
        bit          fl_ok;
        logic [17:0] ed;
        int          n;
        if (!rst_n) begin
            mq.delete();
            m_fp = 1'b0;
            m_wc = 16'd0;
            chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
            chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
            chk("reset_word_count", {16'd0, word_count}, 32'd0);
        end else begin
            ev = (mq.size() >= 18) || (m_fp && mq.size() != 0);
            er = !m_fp && (mq.size() < 18 || out_ready);
            ed = '0;
            for (int i = 0; i < 18 && i < mq.size(); i++) ed[i] = mq[i];
            chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
            chk("in_ready", {31'd0, in_ready}, {31'd0, er});
            chk("word_count", {16'd0, word_count}, {16'd0, m_wc});
            if (ev) chk("out_data", {14'd0, out_data}, {14'd0, ed});
            of    = ev && out_ready;
            inf   = in_valid && er;
            fl_ok = flush && mq.size() != 0;
            n     = of ? ((mq.size() < 18) ? mq.size() : 18) : 0;
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            if (of) begin
                m_wc = m_wc + 16'd1;
                got.push_back(ed);
            end
            if (inf) for (int i = 0; i < 8; i++) mq.push_back(in_data[i]);
            if (mq.size() == 0) m_fp = 1'b0;
            else if (fl_ok) m_fp = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h not accepted, required within 50 cycles", b);
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 200 && !idle; t++) begin
            @(negedge clock);
            idle = !out_valid;
            tick();
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: out_valid still 1, required 0");
        end
    endtask

    task automatic send_1_to_9();
        for (int b = 1; b <= 9; b++) send(8'(b));
    endtask

    task automatic chk_basic_words(input string nm);
        logic [17:0] exp_w [4];
        exp_w[0] = 18'h30201;
        exp_w[1] = 18'h14100;
        exp_w[2] = 18'h07060;
        exp_w[3] = 18'h02420;
        chk({nm, "_count"}, got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk({nm, "_word"}, {14'd0, got[i]}, {14'd0, exp_w[i]});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic packing
        out_ready = 1'b1;
        got.delete();
        send_1_to_9();
        drain();
        chk_basic_words("basic");
        chk("basic_wc", {16'd0, word_count}, 32'd4);
        chk("basic_cnt", {27'd0, dut.cnt_q}, 32'd0);

        // Flush of a partial word
        got.delete();
        send(8'hFF);
        send(8'hAA);
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("flush_word", {14'd0, out_data}, 32'h0AAFF);
            tick();
        end
        drain();
        chk("flush_count", got.size(), 1);
        if (got.size() > 0) chk("flush_got", {14'd0, got[0]}, 32'h0AAFF);
        chk("flush_wc", {16'd0, word_count}, 32'd5);

        // Backpressure, then emit+accept in the same cycle at cnt 24
        got.delete();
        out_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        in_valid = 1'b1;
        in_data  = 8'h04;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", {14'd0, out_data}, 32'h30201);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("simul_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("simul_cnt", {27'd0, dut.cnt_q}, 32'd14);
        for (int b = 5; b <= 9; b++) send(8'(b));
        drain();
        chk_basic_words("bp");

        // Flush with nothing buffered
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("empty_flush_valid", {31'd0, out_valid}, 32'd0);
            chk("empty_flush_pend", {31'd0, dut.flush_pend_q}, 32'd0);
            tick();
        end

        // Reset mid-stream
        for (int b = 1; b <= 5; b++) send(8'(b));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_wc", {16'd0, word_count}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got.delete();
        send_1_to_9();
        drain();
        chk_basic_words("after_reset");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(15) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain();
        chk("final_idle_cnt", {27'd0, dut.cnt_q}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
